// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a one-entry
// holding buffer that absorbs a word returned while decode is stalled.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic [31:0] sign_ext_imm,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic [15:0] imm
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] buf_r;
  logic        valid_r;
  logic [31:0] instr_r;
  logic [31:0] pc4_r;

  logic        redirect_s;
  logic [31:0] pc_plus4_s;
  logic [31:0] branch_tgt_s;
  logic [31:0] jump_tgt_s;
  logic [31:0] target_s;

  // Redirect qualification and target selection; jump wins over branch.
  always_comb begin
    redirect_s   = 1'b0;
    pc_plus4_s   = pc_r + 32'd4;
    branch_tgt_s = pc4_r + {sign_ext_imm[29:0], 2'b00};
    jump_tgt_s   = {pc4_r[31:28], instr_r[25:0], 2'b00};
    target_s     = branch_tgt_s;
    if (!stall && valid_r && (branch_taken || jump)) begin
      redirect_s = 1'b1;
    end else begin
      redirect_s = 1'b0;
    end
    if (jump) begin
      target_s = jump_tgt_s;
    end else begin
      target_s = branch_tgt_s;
    end
  end

  // PC, IF/ID register, holding buffer and FETCH/HOLD state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= FETCH;
      pc_r    <= RESET_PC;
      buf_r   <= 32'h0000_0000;
      valid_r <= 1'b0;
      instr_r <= 32'h0000_0000;
      pc4_r   <= 32'h0000_0000;
    end else if (flush || redirect_s) begin
      // Any buffered or same-cycle word belongs to the squashed path.
      state_r <= FETCH;
      valid_r <= 1'b0;
      buf_r   <= 32'h0000_0000;
      if (redirect_s) begin
        pc_r <= target_s;
      end
    end else begin
      case (state_r)
        FETCH: begin
          if (stall) begin
            if (imem_ready) begin
              buf_r   <= imem_rdata;
              state_r <= HOLD;
            end
          end else if (imem_ready) begin
            instr_r <= imem_rdata;
            pc4_r   <= pc_plus4_s;
            valid_r <= 1'b1;
            pc_r    <= pc_plus4_s;
          end else begin
            valid_r <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            instr_r <= buf_r;
            pc4_r   <= pc_plus4_s;
            valid_r <= 1'b1;
            pc_r    <= pc_plus4_s;
            state_r <= FETCH;
          end
        end
        default: begin
          state_r <= FETCH;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr   = pc_r;
  assign imem_req    = rst_n && (state_r == FETCH);
  assign if_id_valid = valid_r;
  assign if_id_instr = instr_r;
  assign if_id_pc4   = pc4_r;
  assign imm         = instr_r[15:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// traffic, all compared against a queue-based behavioural model.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic        jump;
  logic [31:0] sign_ext_imm;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic [15:0] imm;

  int tests;
  int fails;

  // Reference model state: program counter, IF/ID contents, parked words.
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic [31:0] m_parked[$];

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
    .flush(flush), .branch_taken(branch_taken), .jump(jump),
    .sign_ext_imm(sign_ext_imm), .if_id_valid(if_id_valid),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .imm(imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = RESET_PC;
    m_valid = 1'b0;
    m_instr = 32'h0;
    m_pc4   = 32'h0;
    m_parked.delete();
  endtask

  // Apply one clock of the fetch rules to the model using the current inputs.
  task automatic model_step();
    logic [31:0] jt;
    logic [31:0] bt;
    logic        redir;
    jt    = (m_pc4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 32'd4);
    bt    = m_pc4 + sign_ext_imm * 32'd4;
    redir = !stall && m_valid && (jump || branch_taken);
    if (flush || redir) begin
      if (redir) m_pc = jump ? jt : bt;
      m_valid = 1'b0;
      m_parked.delete();
    end else if (m_parked.size() != 0) begin
      if (!stall) begin
        m_instr = m_parked.pop_front();
        m_pc4   = m_pc + 32'd4;
        m_pc    = m_pc + 32'd4;
        m_valid = 1'b1;
      end
    end else if (stall) begin
      if (imem_ready) m_parked.push_back(imem_rdata);
    end else if (imem_ready) begin
      m_instr = imem_rdata;
      m_pc4   = m_pc + 32'd4;
      m_pc    = m_pc + 32'd4;
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".addr"},  imem_addr, m_pc);
    check({tag, ".req"},   {31'd0, imem_req}, {31'd0, (rst_n === 1'b1) && (m_parked.size() == 0)});
    check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, m_valid});
    check({tag, ".instr"}, if_id_instr, m_instr);
    check({tag, ".pc4"},   if_id_pc4, m_pc4);
    check({tag, ".imm"},   {16'd0, imm}, m_instr & 32'h0000_FFFF);
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    imem_ready   = 1'b0;
    imem_rdata   = 32'h0;
    stall        = 1'b0;
    flush        = 1'b0;
    branch_taken = 1'b0;
    jump         = 1'b0;
    sign_ext_imm = 32'h0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;
    #1;
    check_all("release");

    // Two back-to-back words A, B.
    imem_ready = 1'b1; imem_rdata = 32'hAAAA_0001;
    tick("wordA");
    check("wordA.pc4_const", if_id_pc4, 32'h4);
    imem_rdata = 32'hBBBB_0002;
    tick("wordB");
    check("wordB.addr_const", imem_addr, 32'h8);

    // Word C returns under stall, parks, then drains.
    stall = 1'b1; imem_rdata = 32'hCCCC_0003;
    tick("holdC");
    check("holdC.req_const", {31'd0, imem_req}, 32'h0);
    imem_ready = 1'b0;
    tick("holdC2");
    stall = 1'b0;
    tick("drainC");
    check("drainC.instr_const", if_id_instr, 32'hCCCC_0003);
    check("drainC.addr_const", imem_addr, 32'hC);

    // Reach PC 0xFC via a jump, fetch there, then branch back by 8.
    imem_ready = 1'b1; imem_rdata = 32'h0000_003F;
    tick("jsetup");
    imem_ready = 1'b0; jump = 1'b1;
    tick("jto_fc");
    jump = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h1234_5678;
    tick("fetch_fc");
    check("fetch_fc.pc4_const", if_id_pc4, 32'h100);
    imem_ready = 1'b0; branch_taken = 1'b1; sign_ext_imm = 32'hFFFF_FFFE;
    tick("branch");
    check("branch.addr_const", imem_addr, 32'hF8);
    check("branch.valid_const", {31'd0, if_id_valid}, 32'h0);
    branch_taken = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h2222_0000;
    tick("after_branch");
    check("after_branch.valid_const", {31'd0, if_id_valid}, 32'h1);

    // Branch to 0x1000_0000, fetch the jump word, jump to 0x1000_0100.
    imem_ready = 1'b0; branch_taken = 1'b1; sign_ext_imm = 32'h03FF_FFC1;
    tick("br_far");
    branch_taken = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h0800_0040;
    tick("fetch_j");
    check("fetch_j.pc4_const", if_id_pc4, 32'h1000_0004);
    imem_ready = 1'b0; jump = 1'b1;
    tick("jump");
    check("jump.addr_const", imem_addr, 32'h1000_0100);
    jump = 1'b0;

    // Flush coinciding with a returned word.
    imem_ready = 1'b1; imem_rdata = 32'h3333_0000;
    tick("pre_flush");
    flush = 1'b1; imem_rdata = 32'h4444_0000;
    tick("flush");
    check("flush.addr_const", imem_addr, 32'h1000_0104);
    check("flush.valid_const", {31'd0, if_id_valid}, 32'h0);
    flush = 1'b0;

    // PC wrap past the top of the address space.
    imem_ready = 1'b1; imem_rdata = 32'h5555_0000;
    tick("pre_wrap");
    imem_ready = 1'b0; branch_taken = 1'b1;
    sign_ext_imm = (32'hFFFF_FFFC - m_pc4) >> 2;
    tick("br_top");
    check("br_top.addr_const", imem_addr, 32'hFFFF_FFFC);
    branch_taken = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h6666_0000;
    tick("wrap");
    check("wrap.addr_const", imem_addr, 32'h0);
    check("wrap.pc4_const", if_id_pc4, 32'h0);

    // Asynchronous reset while a word is parked.
    stall = 1'b1; imem_rdata = 32'h7777_0000;
    tick("hold_rst");
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    idle_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_all("rst_release");
    check("rst_release.addr_const", imem_addr, RESET_PC);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      stall        = ($urandom_range(0, 9) < 3);
      imem_ready   = ($urandom_range(0, 9) < 6);
      imem_rdata   = $urandom;
      flush        = ($urandom_range(0, 19) == 0);
      branch_taken = ($urandom_range(0, 9) == 0);
      jump         = ($urandom_range(0, 19) == 0);
      sign_ext_imm = $urandom;
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port imem_addr  output  32  fetch address, equal to current PC.
REQ-005 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-006 SHALL have port imem_ready  input  1  imem_rdata valid for imem_addr this cycle.
REQ-007 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-008 SHALL have port stall  input  1  decode cannot accept a new IF/ID entry.
REQ-009 SHALL have port flush  input  1  invalidate the IF/ID entry.
REQ-010 SHALL have port branch_taken  input  1  take the branch held in IF/ID.
REQ-011 SHALL have port jump  input  1  take the jump held in IF/ID.
REQ-012 SHALL have port sign_ext_imm  input  32  sign-extended branch offset from the sign-extension stage.
REQ-013 SHALL have port if_id_valid  output  1  IF/ID entry holds a live instruction.
REQ-014 SHALL have port if_id_instr  output  32  IF/ID instruction register.
REQ-015 SHALL have port if_id_pc4  output  32  PC+4 of the IF/ID instruction.
REQ-016 SHALL have port imm  output  16  if_id_instr[15:0], fed to the sign-extension stage.

Function
REQ-017 SHALL implement FSM states FETCH (request outstanding) and HOLD (word buffered while stalled).
REQ-018 SHALL drive imem_req = 1 only in FETCH with rst_n high; imem_addr = PC at all times.
REQ-019 SHALL, in FETCH with imem_ready=1 and stall=0, load if_id_instr<=imem_rdata, if_id_pc4<=PC+4, if_id_valid<=1, PC<=PC+4; the instruction appears at the IF/ID outputs one cycle after imem_ready.
REQ-020 SHALL, in FETCH with imem_ready=0 and stall=0, clear if_id_valid and hold PC.
REQ-021 SHALL, in FETCH with imem_ready=1 and stall=1, capture imem_rdata into a one-entry buffer, keep PC, hold IF/ID unchanged, and go to HOLD.
REQ-022 SHALL, in HOLD with stall=1, hold all state and drive imem_req=0.
REQ-023 SHALL, in HOLD with stall=0, move the buffer into IF/ID (valid=1, pc4=PC+4), set PC<=PC+4, and return to FETCH.
REQ-024 SHALL, whenever stall=1 in FETCH with imem_ready=0, hold PC and IF/ID unchanged.
REQ-025 SHALL compute the branch target as if_id_pc4 + {sign_ext_imm[29:0],2'b00}, modulo 2^32.
REQ-026 SHALL compute the jump target as {if_id_pc4[31:28], if_id_instr[25:0], 2'b00}.
REQ-027 SHALL act on a redirect (branch_taken or jump) only when stall=0 and if_id_valid=1; jump has priority if both are asserted.
REQ-028 SHALL, on a qualified redirect, set PC<=target, clear if_id_valid, discard any buffered or same-cycle returned word, and enter FETCH.
REQ-029 SHALL, on flush=1 (stall ignored), clear if_id_valid, discard any buffered or same-cycle word, and enter FETCH; PC advances only if a redirect is also qualified, otherwise it holds.
REQ-030 SHALL give priority: redirect/flush > stall > normal fetch.
REQ-031 SHALL wrap PC+4 from 32'hFFFF_FFFC to 32'h0000_0000 without error.

Reset
REQ-032 SHALL, while rst_n=0, asynchronously force PC=RESET_PC, state=FETCH, if_id_valid=0, if_id_instr=0, if_id_pc4=0, buffer=0, imem_req=0.
REQ-033 SHALL, on reset assertion mid-HOLD or mid-fetch, drop all in-flight data; the first request after release is to RESET_PC.

Verification
REQ-034 SHALL cover: release reset, imem_ready=1 with words A,B -> imem_addr 0,4,8; if_id_instr=A with pc4=4, then B with pc4=8.
REQ-035 SHALL cover: stall=1 during the cycle word C returns at PC=8 -> HOLD, imem_req=0; stall drops -> if_id_instr=C, pc4=12, imem_addr=12.
REQ-036 SHALL cover: IF/ID pc4=0x100, sign_ext_imm=0xFFFF_FFFE, branch_taken=1 -> next imem_addr=0xF8, if_id_valid=0 for one cycle.
REQ-037 SHALL cover: if_id_instr=0x0800_0040, pc4=0x1000_0004, jump=1 -> imem_addr=0x1000_0100.
REQ-038 SHALL cover: flush=1 coinciding with imem_ready=1 -> word discarded, if_id_valid=0, PC unchanged.
REQ-039 SHALL cover: rst_n pulsed low while in HOLD -> outputs take reset values immediately; after release, imem_addr=RESET_PC.
